// File: rtl/batcharger_ctrl.sv
// Battery charger mode sequencer: trickle / constant-current / constant-voltage
// charging with debounced transitions, a CV timeout timer and a temperature fault.
module batcharger_ctrl #(
    parameter int DEB     = 4,
    parameter int CLK_DIV = 1000,
    parameter int VHYST   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] vbat,
    input  logic [7:0] ibat,
    input  logic [7:0] vtemp,
    input  logic [7:0] vcutoff,
    input  logic [7:0] vpreset,
    input  logic [7:0] iend,
    input  logic [7:0] tempmin,
    input  logic [7:0] tempmax,
    input  logic [7:0] tmax,
    output logic       tc,
    output logic       cc,
    output logic       cv,
    output logic       done,
    output logic [2:0] state
);

    // state  | meaning
    // IDLE   | waiting for enable and valid temperature
    // TC     | trickle charge, battery below vcutoff
    // CC     | constant current, battery below vpreset
    // CV     | constant voltage, waiting for end current or timeout
    // END    | charge complete, waiting for discharge below hysteresis
    // TFAULT | temperature out of window while charging

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TC     = 3'd1,
        CC     = 3'd2,
        CV     = 3'd3,
        END    = 3'd4,
        TFAULT = 3'd5
    } state_t;

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t     state_q, state_nx;
    logic [3:0] deb_cnt;
    logic [PW-1:0] presc;
    logic [7:0] timer;
    logic       tick;
    logic       tok;
    logic       cond;
    state_t     target;
    logic [8:0] rearm_lvl;

    assign tok  = (vtemp >= tempmin) && (vtemp <= tempmax);
    assign tick = (presc == PW'(CLK_DIV - 1));

    // Saturating re-arm level: vpreset below VHYST clamps to 0, which never re-arms.
    assign rearm_lvl = ({1'b0, vpreset} >= 9'(VHYST)) ? ({1'b0, vpreset} - 9'(VHYST)) : 9'd0;

    always_comb begin
        cond   = 1'b0;
        target = state_q;
        case (state_q)
            IDLE: begin
                cond = en && tok;
                if (vbat < vcutoff)
                    target = TC;
                else if (vbat < vpreset)
                    target = CC;
                else
                    target = END;
            end
            TC: begin
                cond   = (vbat >= vcutoff);
                target = CC;
            end
            CC: begin
                cond   = (vbat >= vpreset);
                target = CV;
            end
            CV: begin
                cond   = (ibat < iend) || (timer >= tmax);
                target = END;
            end
            END: begin
                cond   = ({1'b0, vbat} < rearm_lvl);
                target = IDLE;
            end
            TFAULT: begin
                cond   = tok;
                target = IDLE;
            end
            default: begin
                cond   = 1'b1;
                target = IDLE;
            end
        endcase
    end

    always_comb begin
        state_nx = state_q;
        if (!en)
            state_nx = IDLE;
        else if (!tok && (state_q == TC || state_q == CC || state_q == CV))
            state_nx = TFAULT;
        else if (cond && deb_cnt == 4'(DEB - 1))
            state_nx = target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            deb_cnt <= 4'd0;
            tc      <= 1'b0;
            cc      <= 1'b0;
            cv      <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nx;
            tc      <= (state_nx == TC);
            cc      <= (state_nx == CC);
            cv      <= (state_nx == CV);
            done    <= (state_nx == END);
            if (!en || state_nx != state_q || !cond)
                deb_cnt <= 4'd0;
            else
                deb_cnt <= deb_cnt + 4'd1;
        end
    end

    // Prescaler and timer only run while in CV, so they are already clear on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            timer <= 8'd0;
        end else if (!en || state_q != CV) begin
            presc <= '0;
            timer <= 8'd0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && timer != 8'hFF)
                timer <= timer + 8'd1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed bench for batcharger_ctrl: walks the charge sequence, fault, timeout,
// re-arm and enable/reset cases, checking state and mode outputs together.
module tb_batcharger_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] vbat, ibat, vtemp, vcutoff, vpreset, iend, tempmin, tempmax, tmax;
    logic       tc, cc, cv, done;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_TC = 3'd1, S_CC = 3'd2,
                           S_CV = 3'd3, S_END = 3'd4, S_TF = 3'd5;

    batcharger_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .vbat(vbat), .ibat(ibat), .vtemp(vtemp),
        .vcutoff(vcutoff), .vpreset(vpreset), .iend(iend), .tempmin(tempmin),
        .tempmax(tempmax), .tmax(tmax), .tc(tc), .cc(cc), .cv(cv), .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    // Packed {state, done, cv, cc, tc} that a given state must show.
    function automatic logic [6:0] expv(input logic [2:0] s);
        return {s, s == S_END, s == S_CV, s == S_CC, s == S_TC};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [2:0] s);
        logic [6:0] obs;
        obs = {state, done, cv, cc, tc};
        total++;
        assert (obs === expv(s)) passed++;
        else $error("FAIL %s: observed state/done/cv/cc/tc=%b required %b", tag, obs, expv(s));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        vbat = 8'd50; ibat = 8'd100; vtemp = 8'd128;
        vcutoff = 8'd100; vpreset = 8'd200; iend = 8'd20;
        tempmin = 8'd20; tempmax = 8'd200; tmax = 8'd255;
        tick(2);
        check("reset", S_IDLE);
        rst = 1'b0;
        tick(1);
        check("post_reset", S_IDLE);

        en = 1'b1;
        tick(3); check("idle_deb_hold", S_IDLE);
        tick(1); check("enter_tc", S_TC);

        vbat = 8'd120;
        tick(3);
        vbat = 8'd50;
        tick(1); check("glitch_no_trans", S_TC);
        tick(4); check("glitch_stay_tc", S_TC);

        vbat = 8'd100;
        tick(3); check("tc_deb_hold", S_TC);
        tick(1); check("enter_cc", S_CC);

        vtemp = 8'd250;
        tick(1); check("tfault_immediate", S_TF);
        vtemp = 8'd128;
        tick(3); check("tfault_deb_hold", S_TF);
        tick(1); check("tfault_clear", S_IDLE);
        tick(3); check("reeval_hold", S_IDLE);
        tick(1); check("reeval_cc", S_CC);

        vbat = 8'd200;
        tick(3); check("cc_deb_hold", S_CC);
        tick(1); check("enter_cv", S_CV);
        ibat = 8'd10;
        tick(3); check("cv_deb_hold", S_CV);
        tick(1); check("end_by_iend", S_END);

        vbat = 8'd195;
        tick(10); check("end_hyst_hold", S_END);
        vbat = 8'd192;
        tick(6); check("end_at_level", S_END);
        vbat = 8'd191;
        tick(3); check("rearm_hold", S_END);
        tick(1); check("rearm_idle", S_IDLE);
        tick(4); check("rearm_cc", S_CC);

        vbat = 8'd200; ibat = 8'd100; tmax = 8'd3;
        tick(4); check("cv_timeout_entry", S_CV);
        tick(3003); check("cv_timeout_hold", S_CV);
        tick(1); check("cv_timeout_end", S_END);

        tmax = 8'd255; vbat = 8'd150;
        tick(4); check("rearm2_idle", S_IDLE);
        tick(4); check("rearm2_cc", S_CC);
        vbat = 8'd200;
        tick(4); check("cv_again", S_CV);
        en = 1'b0;
        tick(1); check("en_off_cv", S_IDLE);

        vbat = 8'd150; en = 1'b1;
        tick(4); check("tmax0_cc", S_CC);
        tmax = 8'd0; vbat = 8'd200;
        tick(4); check("tmax0_cv", S_CV);
        tick(3); check("tmax0_hold", S_CV);
        tick(1); check("tmax0_end", S_END);

        vbat = 8'd150;
        tick(8); check("pre_rst_cc", S_CC);
        #2 rst = 1'b1;
        #1 check("async_rst", S_IDLE);
        #1 rst = 1'b0;
        tick(1); check("post_async_rst", S_IDLE);

        vcutoff = 8'd0; vpreset = 8'd5; vbat = 8'd10;
        tick(4); check("low_preset_end", S_END);
        vbat = 8'd0;
        tick(10); check("low_preset_no_rearm", S_END);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/batcharger_ctrl.md
Name: batcharger_ctrl

Overview:
- Digital charge-mode controller for the battery charger; drives the analog core's tc/cc/cv mode selects.
- Consumes 8-bit ADC codes for battery voltage, battery current and temperature.
- Sequences trickle-charge (TC), constant-current (CC) and constant-voltage (CV) modes.
- Terminates charging on end-of-charge current or the CV timeout, and re-arms on battery discharge.

Parameters:
- DEB, 4: consecutive cycles a transition condition must hold before the state changes (1..15).
- CLK_DIV, 1000: clk cycles per timer tick.
- VHYST, 8: recharge hysteresis in vbat LSBs below vpreset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  charger enable
- vbat  in  8  battery voltage ADC code
- ibat  in  8  battery current ADC code
- vtemp  in  8  temperature ADC code (0 = -40C, 255 = 125C)
- vcutoff  in  8  TC->CC threshold code
- vpreset  in  8  CC->CV threshold code
- iend  in  8  CV end-of-charge current code
- tempmin  in  8  lower temperature limit code
- tempmax  in  8  upper temperature limit code
- tmax  in  8  CV timeout in ticks
- tc  out  1  trickle-charge mode select
- cc  out  1  constant-current mode select
- cv  out  1  constant-voltage mode select
- done  out  1  charge complete
- state  out  3  current state code, for debug

Behaviour:
- Reset, asynchronous: state=IDLE, all counters 0, tc=cc=cv=done=0.
- Outputs are registered and decoded from state:
  - TC -> tc=1; CC -> cc=1; CV -> cv=1; END -> done=1; all other outputs 0.
  - At most one of tc/cc/cv is ever high.
- State encoding: IDLE=0, TC=1, CC=2, CV=3, END=4, TFAULT=5.
- tok = (vtemp >= tempmin) && (vtemp <= tempmax); evaluated every cycle.
- Priority 1, en==0: state goes to IDLE on the next edge, with no debounce. Timer and debounce counters clear.
- Priority 2, en==1 && !tok in TC, CC or CV: go to TFAULT on the next edge, no debounce.
- Priority 3, debounced transitions. The debounce counter increments while the candidate condition is true, clears when it is false, and clears on every state change. The transition fires on the edge where the counter reaches DEB-1 with the condition still true, so the state changes DEB cycles after the condition first holds.
  - IDLE, en && tok:
    - vbat < vcutoff -> TC
    - vcutoff <= vbat < vpreset -> CC
    - vbat >= vpreset -> END
  - TC: vbat >= vcutoff -> CC.
  - CC: vbat >= vpreset -> CV.
  - CV: (ibat < iend) || (timer >= tmax) -> END.
  - END: vbat < vpreset - VHYST -> IDLE. The subtraction saturates at 0, so vpreset < VHYST never re-arms.
  - TFAULT: tok -> IDLE.
- Timer:
  - The prescaler counts 0..CLK_DIV-1 and emits a 1-cycle tick at wrap.
  - The 8-bit timer increments on each tick, only in CV, and saturates at 255.
  - Prescaler and timer clear on entry to CV.
  - tmax==0 forces END after DEB cycles in CV.
- Comparisons are unsigned 8-bit.
- Threshold inputs are sampled every cycle; changes mid-state take effect under the normal debounce rule.
- Reset asserted mid-charge: outputs drop to 0 immediately, with no clock edge required.

Test Plan:
- Reset, then en=1, vtemp=128, tempmin=20, tempmax=200, vbat=50, vcutoff=100, vpreset=200 -> tc=1 exactly DEB(4) cycles after en; cc=cv=done=0.
- From TC, ramp vbat to 100 -> cc=1 after 4 cycles. vbat=200 -> cv=1 after 4 cycles. ibat=10 with iend=20 -> done=1 after 4 cycles, cv=0.
- CV with ibat=100, iend=20, tmax=3, CLK_DIV=1000 -> done=1 at 3000+4 cycles (±1) after CV entry.
- In CC, vtemp=250 -> state=TFAULT and cc=0 on the next edge. vtemp=128 -> IDLE, then CC after re-evaluation.
- In END with vpreset=200, VHYST=8: vbat=195 -> stays END; vbat=191 -> IDLE after 4 cycles, then CC.
- Glitch/enable: in TC, vbat toggles above vcutoff for 3 cycles then drops -> no transition. en=0 mid-CV -> IDLE next edge, all outputs 0. Async rst pulse between edges -> outputs 0 immediately.
